dual_port_mem_responder: RTL
============================

Name: dual_port_mem_responder

Overview:
- Memory-side responder for the CPU's two memory ports: port 0 (instruction fetch, read-only) and port 1 (data, read/write with byte enables).
- Arbitrates between the ports onto a single-ported word array. Inserts a programmable wait-state latency, then returns a one-cycle mem_resp pulse with read data.
- Used as the memory model behind the pipelined datapath, and as the seam where a cache will later be inserted.

Parameters:
- ADDR_W, 12: word-index width; the array holds 2^ADDR_W 16-bit words, indexed by address[ADDR_W:1].
- LATENCY, 3: cycles from request acceptance to mem_resp; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_read_0  in  1  port 0 read request, level, held until mem_resp_0
- mem_address_0  in  16  port 0 byte address
- mem_resp_0  out  1  port 0 completion pulse
- mem_rdata_0  out  16  port 0 read data
- mem_read_1  in  1  port 1 read request, level
- mem_write_1  in  1  port 1 write request, level
- mem_address_1  in  16  port 1 byte address
- mem_wdata_1  in  16  port 1 write data
- mem_byte_enable  in  2  port 1 write lane mask: bit0 = [7:0], bit1 = [15:8]
- mem_resp_1  out  1  port 1 completion pulse
- mem_rdata_1  out  16  port 1 read data
- busy  out  1  high in any state other than IDLE
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; all outputs go to 0; the last_grant flag goes to 0.
  - Array contents are not cleared.
  - Reset during BUSY or RESP abandons the transaction: no write commit and no resp.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - A pending port is one with mem_read_0 high (port 0), or mem_read_1 or mem_write_1 high (port 1).
  - If no port is pending, stay in IDLE.
  - If exactly one port is pending, grant it.
  - If both are pending, grant the port not in last_grant (round-robin). After reset, port 1 wins the first tie.
  - On grant, latch into internal registers: granted port, address[ADDR_W:1], wdata, byte enable, and op (write when mem_write_1, else read).
  - Load the counter with LATENCY-1. Go to RESP if LATENCY==1, else to BUSY.
- BUSY:
  - Decrement the counter each cycle.
  - When the counter reaches 1, the next state is RESP.
  - Request inputs are ignored; latched values are used.
- RESP (exactly one cycle):
  - Assert mem_resp_N for the granted port only.
  - Read: mem_rdata_N = array[latched index], registered so it is valid in the RESP cycle. mem_rdata_N holds its value until that port's next read response.
  - Write: commit to the array at the end of the RESP cycle, per lane, where the byte enable bit is set. Mask 00 commits nothing but still responds. mem_rdata_1 is unchanged on a write.
  - Update last_grant to the granted port. Go to IDLE.
- Latency: a request first seen in IDLE in cycle T gets mem_resp in cycle T+LATENCY. There is a mandatory IDLE cycle between back-to-back transactions.
- Requester rule: the requester drops its request in the cycle after mem_resp. A request still high in the IDLE cycle that follows is treated as a new transaction.
- Address and data widths:
  - address[0] and address[15:ADDR_W+1] are ignored, so addresses wrap modulo 2^(ADDR_W+1) bytes.
  - Byte placement on a write is the requester's job (the datapath already replicates the byte). This block applies only the mask.
- proto_err: set sticky until reset by either of these events:
  - mem_read_1 and mem_write_1 both high at grant; the write takes precedence.
  - A granted port deasserting its request during BUSY; the transaction still completes.
- Read-after-write to the same word, across consecutive transactions, returns the new data.

Decomposition:
- lc3b_types package: add lc3b_mem_mask (logic [1:0]) and enum lc3b_resp_state {IDLE, BUSY, RESP}. Reuse lc3b_word.
- One sub-module: mem_array. It holds 2^ADDR_W words, has a synchronous registered read port, and a write port with a 2-bit lane mask. It has no reset.
- The FSM, arbiter, and counter stay in the top module.

Test Plan:
- Port 0 read, LATENCY=3: preload word 0x0010 with 0x1234, raise mem_read_0 with address 0x0010 in cycle T. Expect mem_resp_0 high only in T+3, mem_rdata_0=0x1234, mem_resp_1 low throughout.
- Port 1 byte writes: write 0xABCD with mask 11 to 0x0020. Then write 0x5555 with mask 01 to 0x0021. Then read 0x0020. Expect 0xAB55.
- Simultaneous requests from reset: both ports request. Port 1 is served first, then port 0. A continued tie then alternates 1,0,1,0, with one IDLE cycle between each resp.
- LATENCY=1: a request in cycle T gives resp in T+1. Back-to-back port 0 reads give resp every 2 cycles.
- Reset mid-write: assert rst_n low during BUSY of a write of 0xFFFF to 0x0030 (prior value 0x0000). Expect resp never pulsed, busy=0 immediately, word reads back 0x0000.
- Protocol error: mem_read_1 and mem_write_1 both high with wdata 0x00FF. Expect the write to commit, proto_err=1 held until reset.

Source files
------------

// File: rtl/dual_port_mem_responder_pkg.sv
// dual_port_mem_responder_pkg: shared word, lane-mask and responder state types
package dual_port_mem_responder_pkg;
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0] lc3b_mem_mask;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} lc3b_resp_state;
endpackage

// File: rtl/dual_port_mem_responder_if.sv
// dual_port_mem_responder_if: instruction/data memory ports plus responder status
interface dual_port_mem_responder_if;
  import dual_port_mem_responder_pkg::*;
  logic mem_read_0;
  lc3b_word mem_address_0;
  logic mem_resp_0;
  lc3b_word mem_rdata_0;
  logic mem_read_1;
  logic mem_write_1;
  lc3b_word mem_address_1;
  lc3b_word mem_wdata_1;
  lc3b_mem_mask mem_byte_enable;
  logic mem_resp_1;
  lc3b_word mem_rdata_1;
  logic busy;
  logic proto_err;
  modport master (
    output mem_read_0, mem_address_0, mem_read_1, mem_write_1, mem_address_1, mem_wdata_1, mem_byte_enable,
    input mem_resp_0, mem_rdata_0, mem_resp_1, mem_rdata_1, busy, proto_err
  );
  modport slave (
    input mem_read_0, mem_address_0, mem_read_1, mem_write_1, mem_address_1, mem_wdata_1, mem_byte_enable,
    output mem_resp_0, mem_rdata_0, mem_resp_1, mem_rdata_1, busy, proto_err
  );
endinterface

// File: rtl/dual_port_mem_responder_mem_array.sv
// mem_array: single-ported word store with registered read and per-lane write mask
module mem_array
  import dual_port_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output lc3b_word          rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  lc3b_word          wdata,
  input  lc3b_mem_mask      wmask
);
  lc3b_word mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we && wmask[0]) mem[waddr][7:0] <= wdata[7:0];
    if (we && wmask[1]) mem[waddr][15:8] <= wdata[15:8];
  end
endmodule

// File: rtl/dual_port_mem_responder.sv
// dual_port_mem_responder: round-robin arbitration of two CPU ports onto one array with fixed latency
module dual_port_mem_responder
  import dual_port_mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 3
) (
  input logic clk,
  input logic rst_n,
  dual_port_mem_responder_if.slave bus
);
  lc3b_resp_state state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic gnt, gnt_nx, last_grant, op_wr, proto_err, perr_nx;
  logic pend_0, pend_1, grant, rd_resp;
  logic [ADDR_W-1:0] idx, addr_sel, raddr;
  lc3b_word wdata, q, hold_0, hold_1;
  lc3b_mem_mask be;
  assign pend_0   = bus.mem_read_0;
  assign pend_1   = bus.mem_read_1 | bus.mem_write_1;
  assign grant    = (state == IDLE) && (pend_0 || pend_1);
  assign gnt_nx   = (pend_0 && pend_1) ? !last_grant : pend_1;
  assign addr_sel = gnt_nx ? bus.mem_address_1[ADDR_W:1] : bus.mem_address_0[ADDR_W:1];
  assign rd_resp  = (state == RESP) && !op_wr;
  // the array read is issued the cycle before RESP so data lands in the RESP cycle
  assign raddr    = (state == IDLE) ? addr_sel : idx;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    perr_nx  = proto_err;
    if (grant) begin
      state_nx = (LATENCY == 1) ? RESP : BUSY;
      cnt_nx   = 4'(LATENCY - 1);
      perr_nx  = proto_err | (gnt_nx & bus.mem_read_1 & bus.mem_write_1);
    end else if (state == BUSY) begin
      state_nx = (cnt == 4'd1) ? RESP : BUSY;
      cnt_nx   = cnt - 4'd1;
      perr_nx  = proto_err | !(gnt ? pend_1 : pend_0);
    end else if (state == RESP) begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      gnt        <= 1'b0;
      last_grant <= 1'b0;
      op_wr      <= 1'b0;
      idx        <= '0;
      wdata      <= '0;
      be         <= '0;
      proto_err  <= 1'b0;
      hold_0     <= '0;
      hold_1     <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      proto_err <= perr_nx;
      if (grant) begin
        gnt   <= gnt_nx;
        op_wr <= gnt_nx & bus.mem_write_1;
        idx   <= addr_sel;
        wdata <= bus.mem_wdata_1;
        be    <= bus.mem_byte_enable;
      end
      if (state == RESP) last_grant <= gnt;
      if (rd_resp && !gnt) hold_0 <= q;
      if (rd_resp && gnt) hold_1 <= q;
    end
  end
  mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .re    (state_nx == RESP),
    .raddr (raddr),
    .rdata (q),
    .we    ((state == RESP) && op_wr),
    .waddr (idx),
    .wdata (wdata),
    .wmask (be)
  );
  assign bus.busy        = state != IDLE;
  assign bus.mem_resp_0  = (state == RESP) && !gnt;
  assign bus.mem_resp_1  = (state == RESP) && gnt;
  assign bus.mem_rdata_0 = (rd_resp && !gnt) ? q : hold_0;
  assign bus.mem_rdata_1 = (rd_resp && gnt) ? q : hold_1;
  assign bus.proto_err   = proto_err;
endmodule
